cpu_status_ctrl: RTL and testbench

Parametrised CPU run/stall/pipeline-reset controller for the RV32I core, sitting between the control/monitor logic and the pipeline stages. It keeps the run state (including a start request pending DDR calibration), merges a configurable number of maskable stall sources, and produces per-stage delayed stall and pipeline-reset vectors of configurable depth. It also provides saturating run-cycle and stall-cycle performance counters and an optional single-step mode.

---
 rtl/cpu_status_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cpu_status_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_status_ctrl.sv
// cpu_status_ctrl: run/stall/pipeline-reset controller for the RV32I core.
// Holds the run state (STOP/PEND/RUN, plus STEP when CPU_STEP_EN is defined),
// merges maskable stall requests, drives per-stage delayed stall and
// pipeline-reset vectors, and keeps saturating run/stall cycle counters.
//
// Optional feature macro: CPU_STEP_EN (adds step_cmd/step_done and STEP state).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   init_calib_complete      memory calibration done
//   cpu_start, quit_cmd      start / stop pulses from control
//   stall_req, stall_mask    NSRC stall requests and ignore mask
//   cnt_clr                  synchronous clear of both counters
//   step_cmd, step_done      single-step request / retired pulse (CPU_STEP_EN)
//   cpu_running              state is RUN or STEP
//   stall                    combined stall (combinational)
//   stall_dly                stall delayed by i+1 cycles at bit i
//   stall_1shot/fin/fin2     stall edge pulses
//   rst_pipe                 pipeline reset pulse delayed by i cycles at bit i
//   run_cnt, stall_cnt       saturating performance counters
module cpu_status_ctrl #(
    parameter int STAGES = 5,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic              cpu_start,
    input  logic              quit_cmd,
    input  logic [NSRC-1:0]   stall_req,
    input  logic [NSRC-1:0]   stall_mask,
    input  logic              cnt_clr,
`ifdef CPU_STEP_EN
    input  logic              step_cmd,
    output logic              step_done,
`endif
    output logic              cpu_running,
    output logic              stall,
    output logic [STAGES-1:0] stall_dly,
    output logic              stall_1shot,
    output logic              stall_fin,
    output logic              stall_fin2,
    output logic [STAGES-1:0] rst_pipe,
    output logic [CNT_W-1:0]  run_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef CPU_STEP_EN
    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_PEND = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_PEND = 2'd1,
        S_RUN  = 2'd2
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [STAGES-1:0]  stall_dly_q, stall_dly_d;
    logic [STAGES-1:0]  rst_pipe_q, rst_pipe_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               req_stall;
    logic               running;
    logic               entering;
`ifdef CPU_STEP_EN
    logic               step_done_q, step_done_d;
`endif

    assign req_stall = |(stall_req & ~stall_mask);

`ifdef CPU_STEP_EN
    assign running = (state_q == S_RUN) || (state_q == S_STEP);
`else
    assign running = (state_q == S_RUN);
`endif

    // Next state; quit beats calibration loss beats start beats step.
    always_comb begin
        state_d = state_q;
`ifdef CPU_STEP_EN
        step_done_d = 1'b0;
`endif
        case (state_q)
            S_STOP: begin
                if (!quit_cmd) begin
                    if (cpu_start) begin
                        state_d = init_calib_complete ? S_RUN : S_PEND;
                    end
`ifdef CPU_STEP_EN
                    else if (step_cmd && init_calib_complete) begin
                        state_d = S_STEP;
                    end
`endif
                end
            end
            S_PEND: begin
                if (quit_cmd) begin
                    state_d = S_STOP;
                end else if (init_calib_complete) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (quit_cmd || !init_calib_complete) begin
                    state_d = S_STOP;
                end
            end
`ifdef CPU_STEP_EN
            S_STEP: begin
                if (quit_cmd || !init_calib_complete) begin
                    state_d = S_STOP;
                end else if (!req_stall) begin
                    // the one unstalled cycle has executed
                    state_d     = S_STOP;
                    step_done_d = 1'b1;
                end
            end
`endif
            default: state_d = S_STOP;
        endcase
    end

    // Pipe reset on any entry into an executing state, and on a commanded
    // stop from RUN; calibration loss stops without a reset pulse.
`ifdef CPU_STEP_EN
    assign entering = (state_d != state_q) &&
                      ((state_d == S_RUN) || (state_d == S_STEP));
`else
    assign entering = (state_d != state_q) && (state_d == S_RUN);
`endif

    always_comb begin
        stall_dly_d = {stall_dly_q[STAGES-2:0], stall};
        rst_pipe_d  = {rst_pipe_q[STAGES-2:0],
                       entering | ((state_q == S_RUN) & quit_cmd)};
    end

    always_comb begin
        run_cnt_d   = run_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            run_cnt_d   = '0;
            stall_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (!(&run_cnt_q)) begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
            end
            if (req_stall && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_STOP;
            stall_dly_q <= '1;
            rst_pipe_q  <= '0;
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_dly_q <= stall_dly_d;
            rst_pipe_q  <= rst_pipe_d;
            run_cnt_q   <= run_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef CPU_STEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_done_q <= 1'b0;
        end else begin
            step_done_q <= step_done_d;
        end
    end

    assign step_done = step_done_q;
`endif

    assign cpu_running = running;
    assign stall       = ~running | req_stall;
    assign stall_dly   = stall_dly_q;
    assign stall_1shot = stall & ~stall_dly_q[0];
    assign stall_fin   = ~stall & stall_dly_q[0];
    assign stall_fin2  = ~stall_dly_q[0] & stall_dly_q[1];
    assign rst_pipe    = rst_pipe_q;
    assign run_cnt     = run_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_cpu_status_ctrl.sv
// tb_cpu_status_ctrl: self-checking bench for cpu_status_ctrl (CNT_W=4).
// Expected output snapshots are queued per cycle and compared at negedge.
module tb_cpu_status_ctrl;

    typedef struct packed {
        logic       rs;
        logic       start;
        logic       quit;
        logic       calib;
        logic       clr;
        logic       step;
        logic [1:0] req;
        logic [1:0] mask;
    } stim_t;

    typedef logic [18:0] exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_calib_complete = 1'b1;
    logic       cpu_start = 1'b0;
    logic       quit_cmd = 1'b0;
    logic [1:0] stall_req = 2'b00;
    logic [1:0] stall_mask = 2'b00;
    logic       cnt_clr = 1'b0;
    logic       step_tb = 1'b0;
    logic       sd_obs;

    logic       cpu_running, stall, stall_1shot, stall_fin, stall_fin2;
    logic [4:0] stall_dly, rst_pipe;
    logic [3:0] run_cnt, stall_cnt;

    int   total = 0;
    int   pass = 0;
    exp_t sb[$];
    exp_t e;
    exp_t obs;

    always #5 clk = ~clk;

    cpu_status_ctrl #(
        .STAGES(5),
        .NSRC  (2),
        .CNT_W (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .init_calib_complete(init_calib_complete),
        .cpu_start          (cpu_start),
        .quit_cmd           (quit_cmd),
        .stall_req          (stall_req),
        .stall_mask         (stall_mask),
        .cnt_clr            (cnt_clr),
`ifdef CPU_STEP_EN
        .step_cmd           (step_tb),
        .step_done          (sd_obs),
`endif
        .cpu_running        (cpu_running),
        .stall              (stall),
        .stall_dly          (stall_dly),
        .stall_1shot        (stall_1shot),
        .stall_fin          (stall_fin),
        .stall_fin2         (stall_fin2),
        .rst_pipe           (rst_pipe),
        .run_cnt            (run_cnt),
        .stall_cnt          (stall_cnt)
    );

`ifndef CPU_STEP_EN
    assign sd_obs = 1'b0;
`endif

    assign obs = {cpu_running, stall, stall_1shot, stall_fin, stall_fin2,
                  rst_pipe, sd_obs, run_cnt, stall_cnt};

    function automatic stim_t S(input logic rs, input logic st,
                                input logic q, input logic c,
                                input logic cl, input logic sp,
                                input logic [1:0] rq,
                                input logic [1:0] mk);
        stim_t s;
        s = '{rs, st, q, c, cl, sp, rq, mk};
        return s;
    endfunction

    function automatic exp_t mk(input logic r, input logic s,
                                input logic o, input logic f,
                                input logic f2, input logic [4:0] rp,
                                input logic sd, input logic [3:0] rc,
                                input logic [3:0] sc);
        return {r, s, o, f, f2, rp, sd, rc, sc};
    endfunction

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic drive(input stim_t s);
        rst                 = s.rs;
        cpu_start           = s.start;
        quit_cmd            = s.quit;
        init_calib_complete = s.calib;
        cnt_clr             = s.clr;
        step_tb             = s.step;
        stall_req           = s.req;
        stall_mask          = s.mask;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        for (int i = 0; i < 2; i++) begin
            st.push_back(S(1, 0, 0, 1, 0, 0, 2'b00, 2'b00));
            ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        end
        for (int i = 0; i < 2; i++) begin
            st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
            ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        end
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL reset[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
        total++;
        if (stall_dly !== 5'b11111)
            $display("FAIL reset_dly got %b required 11111", stall_dly);
        else
            pass++;
    endtask

    task automatic test_start();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 1, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b00001, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 1, 5'b00010, 0, 1, 0));
        // start while running must not re-pulse the pipe reset
        st.push_back(S(0, 1, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b00100, 0, 2, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b01000, 0, 3, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b10000, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b00000, 0, 5, 0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL start[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 0, 0, 1, 1, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 6, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 1, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 1, 1));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 2, 2));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b0, 0, 3, 3));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 1, 5'b0, 0, 4, 3));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b01));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 5, 3));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b01));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 6, 3));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b10, 2'b01));
        ex.push_back(mk(1, 1, 1, 0, 0, 5'b0, 0, 7, 3));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b0, 0, 8, 4));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL stall[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask

    task automatic test_saturate();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 1, 5'b0, 0, 9, 4));
        for (int k = 1; k < 20; k++) begin
            st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
            ex.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, sat(9 + k), 4));
        end
        st.push_back(S(0, 0, 0, 1, 1, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 15, 4));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 1, 0, 0, 5'b0, 0, 0, 0));
        for (int k = 1; k <= 17; k++) begin
            st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
            ex.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, sat(k), sat(k)));
        end
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b0, 0, 15, 15));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL sat[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask

    task automatic test_quit_run();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 1, 5'b00000, 0, 15, 15));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 1, 0, 0, 5'b00001, 0, 15, 15));
        st.push_back(S(0, 0, 0, 1, 1, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00010, 0, 15, 15));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b01000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b10000, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 0, 0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL quit[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask

    task automatic test_pend();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        for (int k = 1; k < 10; k++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
            ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        end
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b00001, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 1, 5'b00010, 0, 1, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b00100, 0, 2, 0));
        // calibration loss: stop without a new pipe reset
        st.push_back(S(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 0, 0, 5'b01000, 0, 3, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 1, 0, 0, 5'b10000, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 4, 0));
        // quit from PEND beats calibration arriving
        st.push_back(S(0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        st.push_back(S(0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL pend[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask

    task automatic test_start_quit();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 1, 1, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        for (int k = 0; k < 2; k++) begin
            st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
            ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 4, 0));
        end
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL start_quit[%0d] got %b required %b",
                         i, obs, e);
            else
                pass++;
        end
    endtask

`ifdef CPU_STEP_EN
    task automatic test_step();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 0, 0, 1, 0, 1, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 0, 0, 0, 5'b00001, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
        ex.push_back(mk(1, 1, 0, 0, 0, 5'b00010, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b00100, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 1, 0, 1, 5'b01000, 1, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b10000, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 4, 0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL step[%0d] got %b required %b", i, obs, e);
            else
                pass++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(0, 1, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b00000, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(1, 0, 0, 1, 0, 5'b00001, 0, 4, 0));
        st.push_back(S(1, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        ex.push_back(mk(0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL rst_mid[%0d] got %b required %b", i, obs, e);
            else
                pass++;
            if (st[i].rs) begin
                total++;
                if (stall_dly !== 5'b11111)
                    $display("FAIL rst_mid_dly[%0d] got %b required 11111",
                             i, stall_dly);
                else
                    pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stall();
        test_saturate();
        test_quit_run();
        test_pend();
        test_start_quit();
`ifdef CPU_STEP_EN
        test_step();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
